// File: rtl/configs_regfile.sv
// rtl/configs_regfile.sv - double-buffered configuration register bank with streamed shadow load
// Shadow words arrive over a valid/ready stream; a one-cycle COMMIT state copies the whole shadow into the active bank.
module configs_regfile #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 20,
  parameter int WRAP      = 0,
  parameter int AW        = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           io_d_in,
  input  logic                        io_d_valid,
  output logic                        io_d_ready,
  input  logic                        io_addr_load,
  input  logic [AW-1:0]               io_addr,
  input  logic                        io_commit,
  input  logic                        io_clr_err,
  output logic [AW-1:0]               io_ptr,
  output logic                        io_full,
  output logic                        io_done,
  output logic                        io_err,
  output logic [WORD_W*NUM_WORDS-1:0] io_configs_out
);

  typedef enum logic {
    S_LOAD   = 1'b0,
    S_COMMIT = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);
  localparam logic [AW-1:0] FULL_IDX = AW'(NUM_WORDS);

  state_e            state_q;
  logic [AW-1:0]     ptr_q;
  logic              full_q;
  logic              done_q;
  logic              err_q;
  logic [WORD_W-1:0] shadow_q [NUM_WORDS];
  logic [WORD_W-1:0] active_q [NUM_WORDS];

  logic          in_load;
  logic          addr_ok;
  logic          addr_bad;
  logic          wr_en;
  logic          wr_last;
  logic          err_set;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] ptr_d;

  assign io_d_ready = in_load && !full_q;

  // A legal address load redirects both the pointer and any same-cycle write.
  always_comb begin
    in_load  = (state_q == S_LOAD);
    addr_ok  = in_load && io_addr_load && (io_addr < FULL_IDX);
    addr_bad = in_load && io_addr_load && !(io_addr < FULL_IDX);
    wr_ptr   = addr_ok ? io_addr : ptr_q;
    wr_en    = io_d_valid && io_d_ready;
    wr_last  = wr_en && (wr_ptr == LAST_IDX);
    err_set  = addr_bad || (in_load && io_d_valid && full_q);
    if (wr_last) begin
      ptr_d = (WRAP != 0) ? '0 : FULL_IDX;
    end else if (wr_en) begin
      ptr_d = wr_ptr + AW'(1);
    end else begin
      ptr_d = wr_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LOAD;
      ptr_q    <= '0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      done_q <= wr_last;
      // A new error in the same cycle as a clear request keeps the flag set.
      err_q  <= err_set ? 1'b1 : (io_clr_err ? 1'b0 : err_q);
      case (state_q)
        S_LOAD: begin
          if (wr_en) begin
            shadow_q[wr_ptr] <= io_d_in;
          end
          ptr_q  <= ptr_d;
          full_q <= (WRAP == 0) && (ptr_d == FULL_IDX);
          if (io_commit) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          active_q <= shadow_q;
          ptr_q    <= '0;
          full_q   <= 1'b0;
          state_q  <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign io_ptr  = ptr_q;
  assign io_full = full_q;
  assign io_done = done_q;
  assign io_err  = err_q;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_out
    assign io_configs_out[k*WORD_W +: WORD_W] = active_q[k];
  end

endmodule

// File: doc/configs_regfile.md
# configs_regfile

Parametrised, clocked successor to the transparent per-word config latches. It accepts configuration words over a valid/ready stream into an auto-incrementing, addressable shadow register bank. A commit strobe copies the whole shadow bank atomically into the active bank that drives the tile's configuration bits. It adds pointer control, full/wrap modes, a completion pulse, sticky error reporting and double buffering, so reconfiguration never exposes partial state to the LUT tile.

## Interface
- WORD_W, 32, width of one configuration word
- NUM_WORDS, 20, number of words in each bank; must be ≥ 2
- WRAP, 0, 1 = pointer wraps to 0 after the last word; 0 = pointer stops at NUM_WORDS (full)
- AW, $clog2(NUM_WORDS+1), pointer/address width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- io_d_in  in  WORD_W  configuration word
- io_d_valid  in  1  word present on io_d_in
- io_d_ready  out  1  block can accept a word this cycle
- io_addr_load  in  1  load write pointer from io_addr
- io_addr  in  AW  new pointer value
- io_commit  in  1  request shadow→active copy
- io_clr_err  in  1  clear io_err
- io_ptr  out  AW  current write pointer
- io_full  out  1  pointer == NUM_WORDS (WRAP=0 only; tied 0 when WRAP=1)
- io_done  out  1  one-cycle pulse: word NUM_WORDS-1 was written
- io_err  out  1  sticky error flag
- io_configs_out  out  WORD_W*NUM_WORDS  active bank; word k at bits [k*WORD_W +: WORD_W]

## Operation
- Write: when io_d_valid && io_d_ready, shadow[ptr] ← io_d_in and ptr ← ptr+1.
- On writing index NUM_WORDS-1 the pointer update depends on WRAP:
  - WRAP=1: ptr ← 0.
  - WRAP=0: ptr ← NUM_WORDS.
- io_done pulses in the cycle after the write to index NUM_WORDS-1.
- io_d_ready = (state == LOAD) && !io_full.
- Address load: io_addr_load with io_addr < NUM_WORDS sets ptr ← io_addr.
  - It has priority over the write pointer. A write in the same cycle targets io_addr, and ptr ← io_addr+1 (wrap/full rules apply).
  - io_addr ≥ NUM_WORDS: ptr is unchanged, io_err is set, and any same-cycle write uses the old ptr.
- io_d_valid while io_full (WRAP=0): the word is dropped and io_err is set. The upstream is expected to hold valid only while ready, so this is a protocol violation.
- State machine:
  - LOAD: default. Moves to COMMIT when io_commit is sampled high. Any write accepted in that same cycle lands in shadow first and is included in the commit.
  - COMMIT: lasts exactly one cycle, with io_d_ready=0. At its closing edge: active ← shadow, ptr ← 0, state → LOAD. io_commit and io_addr_load are ignored while in COMMIT.
- io_full is a state condition in LOAD, not a separate state. Commit is the only exit from full other than an address load.
- io_clr_err clears io_err at the next edge. If clear and a new error occur in the same cycle, set wins.
- The shadow bank is not readable externally. The active bank changes only at the COMMIT edge, and all NUM_WORDS words change together.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - shadow and io_configs_out = 0
  - ptr = 0, io_full = 0, io_done = 0, io_err = 0
  - state = LOAD, io_d_ready = 1 from the first clock after release
- Write latency: a word accepted at edge N appears in shadow after edge N. It is visible on io_configs_out only after a commit.
- Commit latency: io_commit high at edge N puts the block in COMMIT during cycle N+1. io_configs_out updates after edge N+1, and io_d_ready returns to 1 in cycle N+2.
- Throughput: one word per cycle in LOAD.
- io_done and io_err are registered outputs. io_ptr and io_full are registered. io_d_ready is combinational from state and io_full only, never from io_d_valid.
- Reset asserted mid-load or mid-commit: all state clears immediately. A partially loaded shadow is discarded and active returns to 0.

## Test plan
- Reset, then stream 20 words 0x1000_0000+k (WRAP=0):
  - io_done pulses once, io_full=1, io_ptr=20, io_d_ready=0.
  - io_configs_out stays 0 until io_commit.
  - After commit, word k = 0x1000_0000+k, io_ptr=0, io_full=0.
- WRAP=1: write 22 words, value = index, then commit:
  - word0=20, word1=21, words 2..19 = 2..19.
  - io_done pulses once, after the 20th word.
- Address load 7 with a same-cycle write of 0xDEADBEEF, then commit:
  - word7=0xDEADBEEF and io_ptr=0 after commit.
  - Before the commit, io_ptr=8.
  - io_addr=25 → io_err=1 and ptr unchanged. io_clr_err then clears it.
- io_commit and a write of 0xA5A5A5A5 to index 3 in the same cycle:
  - the word is included in io_configs_out.
  - io_d_ready=0 for exactly one cycle.
  - A valid held during the COMMIT cycle is accepted the following cycle at index 0.
- Assert reset mid-stream after 5 words and after a prior commit of all-ones data:
  - io_configs_out=0, io_ptr=0, io_err=0, io_d_ready=1 after release.
